// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the dual-issue hazard detection logic:
// register index width, default sizing, FSM state encoding and a source-lookup helper.
package hazard_detection_unit_pkg;

    // Architectural register index width and the number of index values it can name.
    localparam int unsigned REG_W = 3;
    localparam int unsigned NSLOT = 1 << REG_W;

    // Default register-file size and load-use wait (module parameters start from these).
    localparam int unsigned DEFAULT_NREG           = 8;
    localparam int unsigned DEFAULT_LOAD_USE_STALL = 1;

    // Width of each per-register wait counter (holds up to 3 stall cycles).
    localparam int unsigned CNT_W = 2;

    // Width of the saturating stall statistics counter.
    localparam int unsigned STALL_CNT_W = 8;

    typedef logic [REG_W-1:0] reg_idx_t;

    // RUN: normal dual issue. SPLIT: slot 1 has issued, slot 2 still waiting in ID.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        SPLIT = 1'b1
    } hdu_state_e;

    // True when any of the three named source registers has a pending load.
    // Register 0 is hard-wired and never reported as pending.
    function automatic logic src_pending(
        input logic [NSLOT-1:0] pending,
        input reg_idx_t         rm,
        input reg_idx_t         rn,
        input reg_idx_t         rd
    );
        logic hit;
        hit = 1'b0;
        if (rm != '0 && pending[rm]) hit = 1'b1;
        if (rn != '0 && pending[rn]) hit = 1'b1;
        if (rd != '0 && pending[rd]) hit = 1'b1;
        return hit;
    endfunction

endpackage

// File: rtl/hazard_detection_unit_reg_scoreboard.sv
// Per-register load-use wait counters. A register loaded by an issuing slot-2
// load counts down from LOAD_USE_STALL; nonzero marks the register as pending.
module reg_scoreboard
    import hazard_detection_unit_pkg::*;
#(
    parameter int unsigned NREG           = DEFAULT_NREG,
    parameter int unsigned LOAD_USE_STALL = DEFAULT_LOAD_USE_STALL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [REG_W-1:0] load_reg,
    output logic [NREG-1:0]  nonzero
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_USE_STALL);

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (r == 0) begin : g_zero
            // Register 0 is never written, so it has no counter at all.
            assign nonzero[r] = 1'b0;
        end else begin : g_cnt
            logic [CNT_W-1:0] cnt;

            // Load takes priority over the per-cycle decrement.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt <= '0;
                end else if (load_en && (load_reg == REG_W'(r))) begin
                    cnt <= LOAD_VAL;
                end else if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end
            end

            assign nonzero[r] = (cnt != '0);
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Dual-issue hazard detection: stalls on load-use hazards tracked by the
// register scoreboard and splits a bundle whose slot 2 depends on slot 1.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int unsigned NREG           = DEFAULT_NREG,
    parameter int unsigned LOAD_USE_STALL = DEFAULT_LOAD_USE_STALL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   IF_ID_valid1,
    input  logic                   IF_ID_valid2,
    input  logic [REG_W-1:0]       IF_ID_rm_1,
    input  logic [REG_W-1:0]       IF_ID_rn_1,
    input  logic [REG_W-1:0]       IF_ID_rd_1,
    input  logic [REG_W-1:0]       IF_ID_rm_2,
    input  logic [REG_W-1:0]       IF_ID_rn_2,
    input  logic [REG_W-1:0]       IF_ID_rd_2,
    input  logic                   IF_ID_RegWrite1,
    input  logic                   IF_ID_RegWrite2,
    input  logic                   IF_ID_MemRead2,
    input  logic                   flush,
    output logic                   PC_Write_n,
    output logic                   Bubble1,
    output logic                   Bubble2,
    output logic [NREG-1:0]        busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    hdu_state_e       state_q;
    hdu_state_e       state_d;
    logic [NREG-1:0]  reg_nz;
    logic [NSLOT-1:0] pending;
    logic             hazard1;
    logic             hazard2;
    logic             pair_dep;
    logic             load_en;

    // Counter update is gated on slot 2 actually issuing, which in turn
    // depends on Bubble2 from the FSM below.
    assign load_en = !reset && IF_ID_valid2 && !Bubble2 &&
                     IF_ID_MemRead2 && IF_ID_RegWrite2 && (IF_ID_rd_2 != '0);

    reg_scoreboard #(
        .NREG           (NREG),
        .LOAD_USE_STALL (LOAD_USE_STALL)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .load_reg (IF_ID_rd_2),
        .nonzero  (reg_nz)
    );

    // Widen the pending map to every index a 3-bit field can name;
    // indices beyond NREG are never pending.
    for (genvar r = 0; r < NSLOT; r++) begin : g_pending
        if (r < NREG) begin : g_real
            assign pending[r] = reg_nz[r];
        end else begin : g_none
            assign pending[r] = 1'b0;
        end
    end

    assign hazard1 = IF_ID_valid1 &&
                     src_pending(pending, IF_ID_rm_1, IF_ID_rn_1, IF_ID_rd_1);
    assign hazard2 = IF_ID_valid2 &&
                     src_pending(pending, IF_ID_rm_2, IF_ID_rn_2, IF_ID_rd_2);

    // Slot 2 reads (or overwrites) the register slot 1 is writing in the same bundle.
    assign pair_dep = IF_ID_valid1 && IF_ID_valid2 && IF_ID_RegWrite1 &&
                      (IF_ID_rd_1 != '0) &&
                      ((IF_ID_rd_1 == IF_ID_rm_2) ||
                       (IF_ID_rd_1 == IF_ID_rn_2) ||
                       (IF_ID_rd_1 == IF_ID_rd_2));

    // Pending state is hidden while reset is held so nothing downstream sees a stale wait.
    assign busy = reset ? '0 : reg_nz;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stall/bubble outputs; reset, then flush, take priority over hazards.
    always_comb begin
        state_d    = state_q;
        PC_Write_n = 1'b0;
        Bubble1    = 1'b0;
        Bubble2    = 1'b0;
        if (reset) begin
            state_d = RUN;
        end else if (flush) begin
            Bubble1 = 1'b1;
            Bubble2 = 1'b1;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard1 || hazard2) begin
                        PC_Write_n = 1'b1;
                        Bubble1    = 1'b1;
                        Bubble2    = 1'b1;
                    end else if (pair_dep) begin
                        PC_Write_n = 1'b1;
                        Bubble2    = 1'b1;
                        state_d    = SPLIT;
                    end
                end
                SPLIT: begin
                    Bubble1 = 1'b1;
                    if (hazard2) begin
                        PC_Write_n = 1'b1;
                        Bubble2    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (PC_Write_n && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: a default instance (1-cycle load-use)
// and a second instance with a 3-cycle load-use wait share the same stimulus.
module tb_hazard_detection_unit;

    logic       clk;
    logic       reset;
    logic       IF_ID_valid1, IF_ID_valid2;
    logic [2:0] IF_ID_rm_1, IF_ID_rn_1, IF_ID_rd_1;
    logic [2:0] IF_ID_rm_2, IF_ID_rn_2, IF_ID_rd_2;
    logic       IF_ID_RegWrite1, IF_ID_RegWrite2, IF_ID_MemRead2;
    logic       flush;

    logic       pc, b1, b2;
    logic [7:0] busy, scnt;
    logic       pc3, b1_3, b2_3;
    logic [7:0] busy3, scnt3;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    hazard_detection_unit dut (
        .clk             (clk),
        .reset           (reset),
        .IF_ID_valid1    (IF_ID_valid1),
        .IF_ID_valid2    (IF_ID_valid2),
        .IF_ID_rm_1      (IF_ID_rm_1),
        .IF_ID_rn_1      (IF_ID_rn_1),
        .IF_ID_rd_1      (IF_ID_rd_1),
        .IF_ID_rm_2      (IF_ID_rm_2),
        .IF_ID_rn_2      (IF_ID_rn_2),
        .IF_ID_rd_2      (IF_ID_rd_2),
        .IF_ID_RegWrite1 (IF_ID_RegWrite1),
        .IF_ID_RegWrite2 (IF_ID_RegWrite2),
        .IF_ID_MemRead2  (IF_ID_MemRead2),
        .flush           (flush),
        .PC_Write_n      (pc),
        .Bubble1         (b1),
        .Bubble2         (b2),
        .busy            (busy),
        .stall_count     (scnt)
    );

    hazard_detection_unit #(.LOAD_USE_STALL(3)) dut3 (
        .clk             (clk),
        .reset           (reset),
        .IF_ID_valid1    (IF_ID_valid1),
        .IF_ID_valid2    (IF_ID_valid2),
        .IF_ID_rm_1      (IF_ID_rm_1),
        .IF_ID_rn_1      (IF_ID_rn_1),
        .IF_ID_rd_1      (IF_ID_rd_1),
        .IF_ID_rm_2      (IF_ID_rm_2),
        .IF_ID_rn_2      (IF_ID_rn_2),
        .IF_ID_rd_2      (IF_ID_rd_2),
        .IF_ID_RegWrite1 (IF_ID_RegWrite1),
        .IF_ID_RegWrite2 (IF_ID_RegWrite2),
        .IF_ID_MemRead2  (IF_ID_MemRead2),
        .flush           (flush),
        .PC_Write_n      (pc3),
        .Bubble1         (b1_3),
        .Bubble2         (b2_3),
        .busy            (busy3),
        .stall_count     (scnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slot 1: valid, rm, rn, rd, RegWrite; slot 2: valid, rm, rn, rd, RegWrite, MemRead
    task automatic set_bundle(input logic v1, input logic [2:0] rm1, input logic [2:0] rn1,
                              input logic [2:0] rd1, input logic rw1,
                              input logic v2, input logic [2:0] rm2, input logic [2:0] rn2,
                              input logic [2:0] rd2, input logic rw2, input logic mr2);
        IF_ID_valid1    = v1;
        IF_ID_rm_1      = rm1;
        IF_ID_rn_1      = rn1;
        IF_ID_rd_1      = rd1;
        IF_ID_RegWrite1 = rw1;
        IF_ID_valid2    = v2;
        IF_ID_rm_2      = rm2;
        IF_ID_rn_2      = rn2;
        IF_ID_rd_2      = rd2;
        IF_ID_RegWrite2 = rw2;
        IF_ID_MemRead2  = mr2;
    endtask

    task automatic idle();
        set_bundle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        // Reset held with a bundle that would otherwise split: everything quiet.
        set_bundle(1, 3, 0, 2, 1, 1, 0, 2, 5, 1, 0);
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_b1", 32'(b1), 32'd0);
        check("rst_b2", 32'(b2), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_scnt", 32'(scnt), 32'd0);
        step();
        reset = 1'b0;
        idle();

        // Load r3 in slot 2, then slot 1 consumes r3.
        set_bundle(1, 0, 0, 1, 1, 1, 0, 0, 3, 1, 1);
        @(negedge clk);
        check("ld_pc", 32'(pc), 32'd0);
        check("ld_b2", 32'(b2), 32'd0);
        step();
        set_bundle(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lu_pc", 32'(pc), 32'd1);
        check("lu_b1", 32'(b1), 32'd1);
        check("lu_b2", 32'(b2), 32'd1);
        check("lu_busy", 32'(busy), 32'h08);
        check("lu3_pc_c1", 32'(pc3), 32'd1);
        step();
        @(negedge clk);
        check("lu_go_pc", 32'(pc), 32'd0);
        check("lu_go_b1", 32'(b1), 32'd0);
        check("lu_go_busy", 32'(busy), 32'd0);
        check("lu_scnt", 32'(scnt), 32'd1);
        check("lu3_pc_c2", 32'(pc3), 32'd1);
        step();
        @(negedge clk);
        check("lu3_pc_c3", 32'(pc3), 32'd1);
        step();
        @(negedge clk);
        check("lu3_pc_go", 32'(pc3), 32'd0);
        check("lu3_scnt", 32'(scnt3), 32'd3);
        check("lu3_busy", 32'(busy3), 32'd0);

        // Slot 1 writes r2, slot 2 reads r2: split the bundle.
        do_reset();
        set_bundle(1, 1, 1, 2, 1, 1, 0, 2, 5, 1, 0);
        @(negedge clk);
        check("sp1_pc", 32'(pc), 32'd1);
        check("sp1_b1", 32'(b1), 32'd0);
        check("sp1_b2", 32'(b2), 32'd1);
        step();
        @(negedge clk);
        check("sp2_pc", 32'(pc), 32'd0);
        check("sp2_b1", 32'(b1), 32'd1);
        check("sp2_b2", 32'(b2), 32'd0);
        check("sp2_scnt", 32'(scnt), 32'd1);
        step();
        idle();
        set_bundle(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("sp3_b1", 32'(b1), 32'd0);
        check("sp3_pc", 32'(pc), 32'd0);

        // Load to r0 never creates a wait; writing r0 never creates a pair dependency.
        do_reset();
        set_bundle(1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1);
        step();
        set_bundle(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("r0_pc", 32'(pc), 32'd0);
        check("r0_b1", 32'(b1), 32'd0);
        check("r0_b2", 32'(b2), 32'd0);
        check("r0_busy", 32'(busy), 32'd0);

        // Load r5, then flush during the would-be stall cycle (also carrying a load of r6).
        do_reset();
        set_bundle(1, 0, 0, 1, 1, 1, 0, 0, 5, 1, 1);
        step();
        set_bundle(1, 0, 5, 1, 1, 1, 0, 0, 6, 1, 1);
        flush = 1'b1;
        @(negedge clk);
        check("fl_pc", 32'(pc), 32'd0);
        check("fl_b1", 32'(b1), 32'd1);
        check("fl_b2", 32'(b2), 32'd1);
        check("fl_busy", 32'(busy), 32'h20);
        step();
        idle();
        set_bundle(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("fl_busy_after", 32'(busy), 32'd0);
        check("fl_run_b1", 32'(b1), 32'd0);
        check("fl_scnt", 32'(scnt), 32'd0);

        // 3-cycle instance: enter SPLIT with r4 pending, then reset.
        do_reset();
        set_bundle(0, 0, 0, 0, 0, 1, 0, 0, 4, 1, 1);
        step();
        set_bundle(1, 1, 1, 2, 1, 1, 0, 2, 6, 1, 0);
        @(negedge clk);
        check("rs_a1_pc", 32'(pc3), 32'd1);
        check("rs_a1_b1", 32'(b1_3), 32'd0);
        check("rs_a1_b2", 32'(b2_3), 32'd1);
        check("rs_a1_busy", 32'(busy3), 32'h10);
        step();
        @(negedge clk);
        check("rs_split_b1", 32'(b1_3), 32'd1);
        check("rs_split_b2", 32'(b2_3), 32'd0);
        check("rs_split_busy", 32'(busy3), 32'h10);
        reset = 1'b1;
        #1;
        check("rs_hold_pc", 32'(pc3), 32'd0);
        check("rs_hold_b1", 32'(b1_3), 32'd0);
        check("rs_hold_busy", 32'(busy3), 32'd0);
        step();
        reset = 1'b0;
        set_bundle(1, 4, 0, 1, 1, 1, 4, 0, 7, 1, 0);
        @(negedge clk);
        check("rs_after_b1", 32'(b1_3), 32'd0);
        check("rs_after_b2", 32'(b2_3), 32'd0);
        check("rs_after_pc", 32'(pc3), 32'd0);
        check("rs_after_busy", 32'(busy3), 32'd0);
        check("rs_after_scnt", 32'(scnt3), 32'd0);

        // Repeating load/consume bundle: default instance stalls every other cycle.
        do_reset();
        set_bundle(1, 3, 0, 1, 1, 1, 0, 0, 3, 1, 1);
        repeat (500) step();
        @(negedge clk);
        check("sat_scnt_250", 32'(scnt), 32'd250);
        check("sat3_scnt", 32'(scnt3), 32'd255);
        repeat (20) step();
        @(negedge clk);
        check("sat_scnt_255", 32'(scnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter NREG, default 8, meaning number of architectural registers.
REQ-002 SHALL have parameter LOAD_USE_STALL, default 1, meaning the number of stall cycles a consumer waits after a slot-2 load (range 1..3).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports IF_ID_valid1 and IF_ID_valid2, input, 1 bit each: the slot-1 and slot-2 instructions in ID are real, not bubbles.
REQ-006 SHALL have ports IF_ID_rm_1, IF_ID_rn_1, IF_ID_rd_1, IF_ID_rm_2, IF_ID_rn_2 and IF_ID_rd_2, input, 3 bits each: source and destination register numbers per slot.
REQ-007 SHALL have ports IF_ID_RegWrite1, IF_ID_RegWrite2 and IF_ID_MemRead2, input, 1 bit each: register-write flags per slot and the slot-2 load flag.
REQ-008 SHALL have port flush, input, 1 bit: branch taken; kill both ID instructions this cycle.
REQ-009 SHALL have port PC_Write_n, output, 1 bit: 1 holds PC and IF/ID.
REQ-010 SHALL have ports Bubble1 and Bubble2, output, 1 bit each: insert a NOP into ID/EX for that slot.
REQ-011 SHALL have port busy, output, NREG bits: bit r is 1 while register r has a pending load.
REQ-012 SHALL have port stall_count, output, 8 bits: saturating count of cycles with PC_Write_n=1.

Function
REQ-013 SHALL keep a per-register 2-bit wait counter cnt[r]; cnt[0] SHALL be 0 at all times.
REQ-014 SHALL decrement every nonzero cnt[r] by 1 each cycle.
REQ-015 SHALL load cnt[IF_ID_rd_2] with LOAD_USE_STALL when slot 2 issues with IF_ID_MemRead2=1, IF_ID_RegWrite2=1 and IF_ID_rd_2!=0; the load value SHALL override the decrement.
REQ-016 SHALL define slot hazard(s) as: the slot is valid and cnt of its rm, rn or rd-as-source is nonzero; register 0 SHALL never cause a hazard.
REQ-017 SHALL define the pair dependency as: IF_ID_valid1=1, IF_ID_RegWrite1=1, IF_ID_rd_1!=0, and IF_ID_rd_1 equals IF_ID_rm_2, IF_ID_rn_2 or IF_ID_rd_2 while IF_ID_valid2=1.
REQ-018 SHALL implement a two-state FSM with states RUN and SPLIT.
REQ-019 In RUN with hazard(1) or hazard(2), SHALL drive PC_Write_n=1, Bubble1=1 and Bubble2=1, and remain in RUN.
REQ-020 In RUN with no hazard but a pair dependency, SHALL drive PC_Write_n=1, Bubble1=0 and Bubble2=1, and move to SPLIT.
REQ-021 In RUN otherwise, SHALL drive all three outputs to 0.
REQ-022 In SPLIT, SHALL drive Bubble1=1 (slot 1 has already issued).
REQ-023 In SPLIT with hazard(2), SHALL hold PC_Write_n=1 and Bubble2=1 and stay in SPLIT; otherwise it SHALL drive PC_Write_n=0 and Bubble2=0 and return to RUN.
REQ-024 flush SHALL dominate: PC_Write_n=0, Bubble1=1, Bubble2=1, next state RUN, no cnt load; decrements SHALL continue.
REQ-025 A slot issues exactly when it is valid and its Bubble output is 0.
REQ-026 All outputs other than stall_count SHALL be combinational from state, cnt and inputs.
REQ-027 stall_count SHALL increment when PC_Write_n=1 and SHALL saturate at 255.
REQ-028 busy[r] SHALL equal (cnt[r]!=0).

Reset
REQ-029 On reset=1 at a clock edge, SHALL set all cnt to 0, the state to RUN and stall_count to 0; during reset, PC_Write_n, Bubble1, Bubble2 and busy SHALL be 0.
REQ-030 Reset SHALL abort a SPLIT or any pending load wait immediately, with no residual stall.

Structure
REQ-031 SHALL place REG_W=3, NREG, LOAD_USE_STALL and the RUN/SPLIT state encoding in the shared pipeline package.
REQ-032 SHALL implement the cnt array, load and decrement in one sub-module, reg_scoreboard, which exposes cnt-nonzero per register.

Verification
REQ-033 Load r3 in slot 2, next bundle slot-1 reads rm=3 -> exactly one cycle of PC_Write_n=1, Bubble1=Bubble2=1, busy[3]=1; issues the following cycle.
REQ-034 Bundle with slot 1 writing r2 and slot 2 reading rn=2 -> cycle 1: Bubble2=1, PC_Write_n=1; cycle 2: SPLIT, Bubble1=1, Bubble2=0; stall_count=1.
REQ-035 Load to r0, then a consumer reading r0 -> no stall, busy=0.
REQ-036 Load r5, then flush asserted in the stall cycle -> Bubble1=Bubble2=1, PC_Write_n=0, busy[5] clears on schedule, state RUN.
REQ-037 Reset asserted while in SPLIT with busy[4]=1 -> next cycle state RUN, busy=0, stall_count=0, no bubbles.
REQ-038 Hold a hazard for 300 cycles -> stall_count saturates at 255.
